// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter in front of a single-ported data
// memory. Port 0 is the CPU M stage and port 1 is the DMA/bridge. Each accepted
// request is latched, spends one ACCESS cycle driving the memory, and is
// answered by a one-cycle rvalid pulse with registered rdata/rerr.
module dm_arbiter #(
    parameter int DM_WORDS = 3072,
    parameter int ADDR_HI  = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [31:0] rdata,
    output logic        rerr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic [31:0] DM_LIMIT = 32'(DM_WORDS);

    logic [0:0]  state;
    logic        last;        // port served most recently; 1 after reset so port 0 wins the first tie
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_port;
    logic        accept;
    logic        sel_port;
    logic        cmd_oor;

    // Address check: high bits beyond the DM window, word index past the end
    // of the memory, or a byte address that is not word aligned.
    function automatic logic out_of_range(input logic [31:0] addr);
        logic [31:0] word_idx;
        word_idx = 32'(addr[ADDR_HI:2]);
        return (addr[31:ADDR_HI+1] != '0) ||
               (word_idx >= DM_LIMIT)     ||
               (addr[1:0] != 2'b00);
    endfunction

    assign cmd_oor  = out_of_range(cmd_addr);
    assign accept   = p0_gnt | p1_gnt;
    assign sel_port = p1_gnt;

    // Grant decision: only in IDLE and out of reset; a tie goes to the port
    // that was not served last.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (reset && (state == ST_IDLE)) begin
            if (p0_req && p1_req) begin
                p0_gnt = last;
                p1_gnt = ~last;
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
    end

    // Memory drive: the latched command is presented only during ACCESS, and a
    // write is suppressed when the address is bad or reset is asserted.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (state == ST_ACCESS) begin
            mem_addr  = cmd_addr;
            mem_wdata = cmd_wdata;
            mem_we    = cmd_we & ~cmd_oor & reset;
        end
    end

    // Control FSM and command latch: accept in IDLE, then spend one cycle in
    // ACCESS before returning to IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            last      <= 1'b1;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_port  <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                cmd_port  <= sel_port;
                last      <= sel_port;
                state     <= ST_ACCESS;
                if (sel_port) begin
                    cmd_we    <= p1_we;
                    cmd_addr  <= p1_addr;
                    cmd_wdata <= p1_wdata;
                end else begin
                    cmd_we    <= p0_we;
                    cmd_addr  <= p0_addr;
                    cmd_wdata <= p0_wdata;
                end
            end
        end else begin
            state <= ST_IDLE;
        end
    end

    // Response register: capture the result at the end of ACCESS and raise the
    // owning port's rvalid for exactly the following cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata     <= '0;
            rerr      <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else if (state == ST_ACCESS) begin
            rdata     <= (!cmd_we && !cmd_oor) ? mem_rdata : '0;
            rerr      <= cmd_oor;
            p0_rvalid <= ~cmd_port;
            p1_rvalid <= cmd_port;
        end else begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end
    end

endmodule
